// File: rtl/dec_pkg.sv
// Shared widths and FIFO state encoding for the 3-to-8 decoder pipeline.
package dec_pkg;

    localparam int CODE_W = 3;
    localparam int OH_W   = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } fifo_state_t;

endpackage : dec_pkg

// File: rtl/dec3to8_core.sv
// Combinational 3-to-8 one-hot decode; an all-zero source decodes to no bit set.
module dec3to8_core
    import dec_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic              nz,
    output logic [OH_W-1:0]   onehot
);

    always_comb begin
        // NOTE: default first so every path assigns onehot; otherwise a latch is inferred.
        onehot = '0;
        if (nz) begin
            onehot[code] = 1'b1;
        end
    end

endmodule : dec3to8_core

// File: rtl/dec3to8_pipe.sv
// Decoder feeding a 2-entry valid/ready FIFO, plus a sticky OR-accumulator of accepted words.
module dec3to8_pipe
    import dec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic              in_nz,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OH_W-1:0]   out_onehot,
    input  logic              acc_clr,
    output logic [OH_W-1:0]   acc_mask,
    output logic              acc_full
);

    fifo_state_t     state;
    fifo_state_t     state_nxt;
    logic [OH_W-1:0] dec_word;
    logic [OH_W-1:0] head;
    logic [OH_W-1:0] tail;
    logic            push;
    logic            pop;

    dec3to8_core u_core (
        .code   (in_code),
        .nz     (in_nz),
        .onehot (dec_word)
    );

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = TWO;
                else if (!push && pop) state_nxt = EMPTY;
            end
            TWO:     if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Handshake flags depend only on state, so in_ready never sees out_ready combinationally.
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        unique case (state)
            EMPTY: begin
                in_ready  = 1'b1;
                out_valid = 1'b0;
            end
            ONE: begin
                in_ready  = 1'b1;
                out_valid = 1'b1;
            end
            TWO: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // NOTE: only two words of storage, so both entries are reset to give a defined out_onehot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            unique case (state)
                EMPTY: if (push) head <= dec_word;
                ONE: begin
                    if (push && pop) head <= dec_word;
                    else if (push)   tail <= dec_word;
                end
                TWO:     if (pop) head <= tail;
                default: ;
            endcase
        end
    end

    assign out_onehot = head;

    // A clear coinciding with an accepted word keeps only that word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_mask <= '0;
        end else if (push) begin
            acc_mask <= acc_clr ? dec_word : (acc_mask | dec_word);
        end else if (acc_clr) begin
            acc_mask <= '0;
        end
    end

    assign acc_full = &acc_mask;

endmodule : dec3to8_pipe

// File: doc/dec3to8_pipe.md
DEC3TO8_PIPE -- requirements
Module: dec3to8_pipe

Interface
REQ-001 SHALL have these ports, clock and reset first, one per line below.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 in_valid  input  1  an input word is offered.
REQ-005 in_ready  output  1  block can accept an input word.
REQ-006 in_code  input  3  encoded index, 0..7.
REQ-007 in_nz  input  1  source-nonzero flag; 0 means the source was all-zero, so in_code is ignored.
REQ-008 out_valid  output  1  out_onehot holds a valid word.
REQ-009 out_ready  input  1  sink accepts the word.
REQ-010 out_onehot  output  8  decoded word: bit in_code set, or 8'h00 when in_nz=0.
REQ-011 acc_clr  input  1  clears the accumulated mask.
REQ-012 acc_mask  output  8  OR of all one-hot words accepted since the last clear.
REQ-013 acc_full  output  1  high when acc_mask==8'hFF.
REQ-014 Parameters: none; widths are fixed as CODE_W=3 and OH_W=8.

Function
REQ-015 An input transfer SHALL occur when in_valid&&in_ready at a rising edge; an output transfer SHALL occur when out_valid&&out_ready at a rising edge.
REQ-016 Decode SHALL be: out word = (in_nz ? 8'b1<<in_code : 8'h00), computed at acceptance and stored.
REQ-017 Storage SHALL be a 2-entry FIFO with state machine states EMPTY, ONE and TWO.
REQ-018 EMPTY: an input transfer SHALL move the state to ONE; otherwise the state SHALL stay EMPTY.
REQ-019 ONE: input only SHALL move to TWO; output only SHALL move to EMPTY; both or neither SHALL stay ONE.
REQ-020 TWO: an output transfer SHALL move to ONE; otherwise the state SHALL stay TWO.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO; in_ready SHALL NOT depend combinationally on out_ready.
REQ-022 out_valid SHALL be 1 in ONE and TWO; out_onehot SHALL be the oldest entry.
REQ-023 Latency: a word accepted at edge N SHALL appear on out_onehot with out_valid=1 after edge N, provided the FIFO was EMPTY.
REQ-024 Ordering SHALL be strict FIFO, with no drop or duplication.
REQ-025 Simultaneous input and output transfers in ONE SHALL replace the head with the new word; state SHALL remain ONE.
REQ-026 out_onehot SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 acc_mask update SHALL be applied at each input transfer: acc_mask |= decoded word; an in_nz=0 word SHALL leave the mask unchanged.
REQ-028 acc_clr without an input transfer SHALL set acc_mask to 8'h00.
REQ-029 acc_clr together with an input transfer SHALL set acc_mask to the new decoded word only.
REQ-030 acc_full SHALL be registered-equivalent, i.e. a pure function of the acc_mask register.
REQ-031 in_valid while in TWO SHALL have no effect; the source holds the word.

Reset
REQ-032 rst_n=0 SHALL immediately force state EMPTY, in_ready=1, out_valid=0, out_onehot=8'h00, acc_mask=8'h00 and acc_full=0.
REQ-033 Reset mid-operation SHALL discard all FIFO contents; the first transfer after deassertion SHALL behave as from EMPTY.
REQ-034 Reset deassertion SHALL be assumed synchronized externally; the block SHALL tolerate deassertion on any edge.

Structure
REQ-035 Shared package dec_pkg SHALL hold CODE_W, OH_W and the FIFO state enum {EMPTY, ONE, TWO}.
REQ-036 The combinational decode SHALL be one sub-module, dec3to8_core (code, nz -> onehot), instantiated once at the input.
REQ-037 FIFO entries, state and acc_mask SHALL be flops with rst_n in the sensitivity list.

Verification
REQ-038 Scenario: reset, then code=5, nz=1, out_ready=1 -> out_onehot=8'h20 one cycle later, and acc_mask=8'h20.
REQ-039 Scenario: out_ready=0, send codes 1 and 2 -> state TWO, in_ready=0. Then a third word is held off; release out_ready -> 8'h02 then 8'h04 in order.
REQ-040 Scenario: nz=0, code=7 -> out_onehot=8'h00, acc_mask unchanged.
REQ-041 Scenario: send codes 0..7 -> acc_mask=8'hFF and acc_full=1. Then acc_clr plus code=3 in the same cycle -> acc_mask=8'h08 and acc_full=0.
REQ-042 Scenario: in ONE, in and out transfers in the same cycle for 10 cycles -> no loss, order kept, state stays ONE.
REQ-043 Scenario: assert rst_n=0 mid-stream while in TWO -> out_valid=0 and acc_mask=8'h00 immediately, without waiting for a clock edge.
